grid_walker: RTL and testbench



---
 rtl/grid_walker_pkg.sv | 26 ++
 rtl/grid_walker_step.sv | 30 +++
 rtl/grid_walker.sv | 136 +++++++++++++
 tb/tb_grid_walker.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_walker_pkg.sv
// Shared types and helpers for the grid walker: command directions, FSM states,
// and direction decode used by the step datapath.
package grid_walker_pkg;

  typedef enum logic [1:0] {
    WEST  = 2'b00,
    NORTH = 2'b01,
    EAST  = 2'b10,
    SOUTH = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic dir_is_x(input dir_t d);
    return (d == WEST) || (d == EAST);
  endfunction

  function automatic logic dir_is_inc(input dir_t d);
    return (d == NORTH) || (d == EAST);
  endfunction

endpackage

// File: rtl/grid_walker_step.sv
// Combinational unit step of one coordinate: +1 or -1 with clamp or wrap at
// the grid bounds [0, GRID_MAX]; at_edge flags a step that hit a bound.
module grid_step #(
  parameter int COORD_W  = 5,
  parameter int GRID_MAX = 31,
  parameter int WRAP     = 0
) (
  input  logic [COORD_W-1:0] coord,
  input  logic               inc,
  output logic [COORD_W-1:0] nxt,
  output logic               at_edge
);

  localparam logic [COORD_W-1:0] MAXV = COORD_W'(GRID_MAX);

  always_comb begin
    at_edge = inc ? (coord == MAXV) : (coord == '0);
    nxt     = coord;
    if (at_edge) begin
      if (WRAP != 0) begin
        nxt = inc ? '0 : MAXV;
      end
    end else if (inc) begin
      nxt = coord + COORD_W'(1);
    end else begin
      nxt = coord - COORD_W'(1);
    end
  end

endmodule

// File: rtl/grid_walker.sv
// Sequential grid position walker: executes load and direction/jump commands
// one unit step per clock with clamp or wrap at the grid edges.
//
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   STEP  | one unit step per cycle on the latched axis, remaining counts down
//   DONE  | done/hit_edge presented for one cycle, then back to IDLE
module grid_walker
  import grid_walker_pkg::*;
#(
  parameter int COORD_W  = 5,
  parameter int GRID_MAX = 31,
  parameter int JUMP_W   = 2,
  parameter int WRAP     = 0,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_load,
  input  logic [1:0]         cmd_dir,
  input  logic [JUMP_W-1:0]  cmd_jump,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               done,
  output logic               hit_edge,
  output logic [CNT_W-1:0]   move_cnt
);

  localparam logic [COORD_W-1:0] MAXV = COORD_W'(GRID_MAX);

  state_t              state_q, state_d;
  dir_t                dir_q;
  logic [JUMP_W-1:0]   rem_q;
  logic                edge_q, edge_d;
  logic                accept;
  logic                axis_x, step_inc;
  logic [COORD_W-1:0]  step_in, step_nxt;
  logic                step_edge, clamp_stop;
  logic [COORD_W-1:0]  load_x_c, load_y_c;

  assign axis_x     = dir_is_x(dir_q);
  assign step_inc   = dir_is_inc(dir_q);
  assign step_in    = axis_x ? pos_x : pos_y;
  assign clamp_stop = step_edge && (WRAP == 0);
  assign load_x_c   = (int'(load_x) > GRID_MAX) ? MAXV : load_x;
  assign load_y_c   = (int'(load_y) > GRID_MAX) ? MAXV : load_y;

  grid_step #(
    .COORD_W (COORD_W),
    .GRID_MAX(GRID_MAX),
    .WRAP    (WRAP)
  ) u_step (
    .coord  (step_in),
    .inc    (step_inc),
    .nxt    (step_nxt),
    .at_edge(step_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_load || (cmd_jump == '0)) state_d = DONE;
          else                              state_d = STEP;
        end
      end
      STEP: begin
        if (clamp_stop || (rem_q == JUMP_W'(1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    accept    = cmd_valid && cmd_ready;
  end

  // Edge flag accumulates over a command; a new command always starts clean.
  always_comb begin
    edge_d = edge_q;
    if (accept)                 edge_d = 1'b0;
    else if (state_q == STEP)   edge_d = edge_q | step_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x    <= '0;
      pos_y    <= '0;
      dir_q    <= WEST;
      rem_q    <= '0;
      edge_q   <= 1'b0;
      done     <= 1'b0;
      hit_edge <= 1'b0;
      move_cnt <= '0;
    end else begin
      edge_q   <= edge_d;
      done     <= (state_d == DONE);
      hit_edge <= (state_d == DONE) ? edge_d : 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (cmd_load) begin
              pos_x <= load_x_c;
              pos_y <= load_y_c;
            end else if (cmd_jump != '0) begin
              dir_q <= dir_t'(cmd_dir);
              rem_q <= cmd_jump;
            end
          end
        end
        STEP: begin
          rem_q <= rem_q - JUMP_W'(1);
          if (!clamp_stop) begin
            if (axis_x) pos_x <= step_nxt;
            else        pos_y <= step_nxt;
            if (move_cnt != '1) move_cnt <= move_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_walker.sv
// Scoreboard bench for grid_walker: unit 0 clamps at the edges, unit 1 wraps.
module tb_grid_walker;
  import grid_walker_pkg::*;

  localparam int CW = 5;
  localparam int GM = 31;
  localparam int JW = 2;
  localparam int NW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           cmd_valid, cmd_load;
  logic [1:0][1:0]      cmd_dir;
  logic [1:0][JW-1:0]   cmd_jump;
  logic [1:0][CW-1:0]   load_x, load_y;
  wire  [1:0]           cmd_ready, done, hit_edge;
  wire  [1:0][CW-1:0]   pos_x, pos_y;
  wire  [1:0][NW-1:0]   move_cnt;

  grid_walker #(.COORD_W(CW), .GRID_MAX(GM), .JUMP_W(JW), .WRAP(0), .CNT_W(NW)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_load(cmd_load[0]), .cmd_dir(cmd_dir[0]), .cmd_jump(cmd_jump[0]),
    .load_x(load_x[0]), .load_y(load_y[0]), .pos_x(pos_x[0]), .pos_y(pos_y[0]),
    .done(done[0]), .hit_edge(hit_edge[0]), .move_cnt(move_cnt[0]));

  grid_walker #(.COORD_W(CW), .GRID_MAX(GM), .JUMP_W(JW), .WRAP(1), .CNT_W(NW)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_load(cmd_load[1]), .cmd_dir(cmd_dir[1]), .cmd_jump(cmd_jump[1]),
    .load_x(load_x[1]), .load_y(load_y[1]), .pos_x(pos_x[1]), .pos_y(pos_y[1]),
    .done(done[1]), .hit_edge(hit_edge[1]), .move_cnt(move_cnt[1]));

  typedef struct packed {
    logic          hit;
    logic [NW-1:0] cnt;
  } res_t;

  logic [2*CW-1:0] trace_q[$];
  res_t            res_q[$];
  int mx[2], my[2], mc[2];
  int nvec = 0;
  int nerr = 0;

  // Reference model: per-cycle expected position after acceptance plus the final result.
  task automatic model_cmd(input int u, input bit ld, input logic [1:0] d, input int j,
                           input int lx, input int ly);
    int x, y, v;
    bit hit, isx, inc, edg;
    x = mx[u]; y = my[u]; hit = 1'b0;
    isx = (d == 2'b00) || (d == 2'b10);
    inc = (d == 2'b01) || (d == 2'b10);
    if (ld) begin
      x = (lx > GM) ? GM : lx;
      y = (ly > GM) ? GM : ly;
    end
    trace_q.push_back({CW'(x), CW'(y)});
    if (!ld) begin
      for (int s = 1; s <= j; s++) begin
        v = isx ? x : y;
        edg = inc ? (v == GM) : (v == 0);
        if (edg && u == 0) begin
          hit = 1'b1;
          trace_q.push_back({CW'(x), CW'(y)});
          break;
        end
        if (edg) begin
          hit = 1'b1;
          v = inc ? 0 : GM;
        end else begin
          v = inc ? v + 1 : v - 1;
        end
        if (isx) x = v; else y = v;
        if (mc[u] < 255) mc[u]++;
        trace_q.push_back({CW'(x), CW'(y)});
      end
    end
    mx[u] = x; my[u] = y;
    res_q.push_back({hit, NW'(mc[u])});
  endtask

  task automatic send(input int u, input bit ld, input logic [1:0] d, input int j,
                      input int lx, input int ly);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready[u] && t < 50) begin
      @(negedge clk);
      t++;
    end
    nvec++;
    if (cmd_ready[u] !== 1'b1) begin
      nerr++;
      $display("FAIL ready_wait u%0d: cmd_ready=%b required 1", u, cmd_ready[u]);
    end
    cmd_valid[u] = 1'b1;
    cmd_load[u]  = ld;
    cmd_dir[u]   = d;
    cmd_jump[u]  = JW'(j);
    load_x[u]    = CW'(lx);
    load_y[u]    = CW'(ly);
    model_cmd(u, ld, d, j, lx, ly);
  endtask

  // Pops the scoreboard for the outstanding command and checks it cycle by cycle.
  task automatic collect(input int u, input bit hold, input string name);
    res_t            r;
    logic [2*CW-1:0] e;
    int              last;
    last = trace_q.size() - 1;
    r = res_q.pop_front();
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      if (hold) begin
        cmd_dir[u]  = 2'($urandom_range(0, 3));
        cmd_jump[u] = JW'($urandom_range(0, 3));
        cmd_load[u] = 1'($urandom_range(0, 1));
        load_x[u]   = CW'($urandom_range(0, GM));
      end else begin
        cmd_valid[u] = 1'b0;
      end
      e = trace_q.pop_front();
      nvec++;
      if ({pos_x[u], pos_y[u]} !== e) begin
        nerr++;
        $display("FAIL %s pos[%0d] u%0d: got (%0d,%0d) want (%0d,%0d)", name, i, u,
                 pos_x[u], pos_y[u], e[2*CW-1:CW], e[CW-1:0]);
      end
      nvec++;
      if (done[u] !== logic'(i == last)) begin
        nerr++;
        $display("FAIL %s done[%0d] u%0d: got %b want %b", name, i, u, done[u], i == last);
      end
      nvec++;
      if (cmd_ready[u] !== 1'b0) begin
        nerr++;
        $display("FAIL %s ready_busy[%0d] u%0d: got %b want 0", name, i, u, cmd_ready[u]);
      end
      if (i == last) begin
        cmd_valid[u] = 1'b0;
        nvec++;
        if (hit_edge[u] !== r.hit) begin
          nerr++;
          $display("FAIL %s hit_edge u%0d: got %b want %b", name, u, hit_edge[u], r.hit);
        end
        nvec++;
        if (move_cnt[u] !== r.cnt) begin
          nerr++;
          $display("FAIL %s move_cnt u%0d: got %0d want %0d", name, u, move_cnt[u], r.cnt);
        end
      end
    end
    @(negedge clk);
    nvec++;
    if (done[u] !== 1'b0 || cmd_ready[u] !== 1'b1) begin
      nerr++;
      $display("FAIL %s after_done u%0d: done=%b ready=%b want done=0 ready=1", name, u,
               done[u], cmd_ready[u]);
    end
  endtask

  task automatic check_reset_vals(input string name);
    for (int u = 0; u < 2; u++) begin
      nvec++;
      if (pos_x[u] !== '0 || pos_y[u] !== '0 || done[u] !== 1'b0 || hit_edge[u] !== 1'b0 ||
          move_cnt[u] !== '0 || cmd_ready[u] !== 1'b1) begin
        nerr++;
        $display("FAIL %s u%0d: pos=(%0d,%0d) done=%b hit=%b cnt=%0d ready=%b want all 0, ready=1",
                 name, u, pos_x[u], pos_y[u], done[u], hit_edge[u], move_cnt[u], cmd_ready[u]);
      end
    end
  endtask

  task automatic model_reset();
    trace_q.delete();
    res_q.delete();
    for (int u = 0; u < 2; u++) begin
      mx[u] = 0; my[u] = 0; mc[u] = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = '0; cmd_load = '0; cmd_dir = '0; cmd_jump = '0; load_x = '0; load_y = '0;
    model_reset();
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_release");
  endtask

  task automatic test_load_and_move();
    send(0, 1'b1, WEST, 0, 5, 9);
    collect(0, 1'b0, "load_5_9");
    send(0, 1'b0, EAST, 3, 0, 0);
    collect(0, 1'b0, "east3");
    send(0, 1'b0, NORTH, 2, 0, 0);
    collect(0, 1'b0, "north2");
  endtask

  task automatic test_clamp();
    send(0, 1'b1, WEST, 0, 30, 0);
    collect(0, 1'b0, "load_30_0");
    send(0, 1'b0, EAST, 3, 0, 0);
    collect(0, 1'b0, "clamp_east");
    send(0, 1'b0, SOUTH, 1, 0, 0);
    collect(0, 1'b0, "clamp_south_first");
    send(0, 1'b1, WEST, 0, 1, 31);
    collect(0, 1'b0, "load_1_31");
    send(0, 1'b0, WEST, 3, 0, 0);
    collect(0, 1'b0, "clamp_west");
  endtask

  task automatic test_wrap();
    send(1, 1'b1, WEST, 0, 0, 1);
    collect(1, 1'b0, "w_load_0_1");
    send(1, 1'b0, SOUTH, 2, 0, 0);
    collect(1, 1'b0, "wrap_south");
    send(1, 1'b1, WEST, 0, 30, 0);
    collect(1, 1'b0, "w_load_30_0");
    send(1, 1'b0, EAST, 3, 0, 0);
    collect(1, 1'b0, "wrap_east");
    send(1, 1'b0, WEST, 2, 0, 0);
    collect(1, 1'b0, "wrap_west");
  endtask

  task automatic test_hold_and_zero();
    send(0, 1'b1, WEST, 0, 10, 10);
    collect(0, 1'b0, "load_10_10");
    send(0, 1'b0, NORTH, 3, 0, 0);
    collect(0, 1'b1, "hold_north3");
    send(0, 1'b0, NORTH, 0, 0, 0);
    collect(0, 1'b0, "north_zero");
  endtask

  task automatic test_back_to_back();
    bit ld;
    for (int n = 0; n < 240; n++) begin
      int u;
      u = (n < 60) ? 0 : 1;
      ld = ($urandom_range(0, 7) == 0);
      send(u, ld, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, GM)), int'($urandom_range(0, GM)));
      collect(u, 1'b0, "b2b");
    end
  endtask

  task automatic test_reset_mid();
    send(1, 1'b0, EAST, 3, 0, 0);
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nvec++;
      if (done[1] !== 1'b0 || pos_x[1] !== '0 || cmd_ready[1] !== 1'b1) begin
        nerr++;
        $display("FAIL reset_mid_after[%0d]: done=%b pos_x=%0d ready=%b want 0,0,1", i,
                 done[1], pos_x[1], cmd_ready[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_and_move();
    test_clamp();
    test_wrap();
    test_hold_and_zero();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
